// File: rtl/neuron_mac_pkg.sv
// neuron_pkg: shared types and helpers for the neuron accumulator family.
//   DATA_W_DEF / FRAC_W_DEF : default Q12.4 data format
//   state_t                 : neuron_mac sequencing states
//   sat_to_width()          : clamp a signed value (up to SAT_MAX_W bits)
//                             into an out_w-bit signed range, with a flag
package neuron_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 4;

  // Widest value sat_to_width can take; out_w must stay below this.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] val;
    logic                        sat;
  } sat_res_t;

  function automatic sat_res_t sat_to_width(input logic signed [SAT_MAX_W-1:0] x,
                                            input int out_w);
    sat_res_t r;
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    one   = SAT_MAX_W'(1);
    hi    = (one <<< (out_w - 1)) - one;
    lo    = -(one <<< (out_w - 1));
    r.sat = (x > hi) || (x < lo);
    if (x > hi)      r.val = hi;
    else if (x < lo) r.val = lo;
    else             r.val = x;
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: pair-input / result-output handshake bundle.
//   master : feed side (drives pairs, bias, out_ready)
//   slave  : neuron side (drives in_ready, out_valid, out, sat)
interface neuron_mac_if
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] value;
  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out;
  logic                     sat;

  modport master (
    output in_valid, value, weight, bias, out_ready,
    input  in_ready, out_valid, out, sat
  );

  modport slave (
    input  in_valid, value, weight, bias, out_ready,
    output in_ready, out_valid, out, sat
  );
endinterface

// File: rtl/neuron_mac_fx_saturate.sv
// fx_saturate: combinational signed narrowing with saturation.
//   in  [IN_W]  : signed value to narrow (IN_W <= 64)
//   out [OUT_W] : in clamped to the OUT_W signed range (OUT_W < 64)
//   sat         : 1 when clamping happened
module fx_saturate
  import neuron_pkg::*;
#(
  parameter int IN_W  = 38,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in,
  output logic signed [OUT_W-1:0] out,
  output logic                    sat
);

  sat_res_t r;
  logic     unused_hi;

  always_comb begin
    r   = sat_to_width(SAT_MAX_W'(in), OUT_W);
    out = r.val[OUT_W-1:0];
    sat = r.sat;
  end

  // Upper bits are a sign copy after clamping; only the low OUT_W matter.
  assign unused_hi = ^r.val[SAT_MAX_W-1:OUT_W];

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: fixed-point neuron. Accumulates N_INPUTS signed value*weight
// products at full precision, adds bias, rescales by FRAC_W, saturates to
// DATA_W, optionally applies ReLU, and holds the result until accepted.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : neuron_mac_if.slave (pair input, bias, result output)
//
// state | meaning
// ------+---------------------------------------------------------
// ACCUM | accepting pairs, in_ready=1, count tracks pairs taken
// FINAL | one cycle: bias add, rescale, saturate, ReLU, register
// HOLD  | result held with out_valid=1 until out_ready
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int N_INPUTS = 10,
  parameter int ACC_W    = 2*DATA_W + $clog2(N_INPUTS) + 1,
  parameter bit RELU_EN  = 1'b1
) (
  input logic         clk,
  input logic         reset,
  neuron_mac_if.slave bus
);

  localparam int CNT_W = $clog2(N_INPUTS) + 1;
  // One guard bit so acc + shifted bias can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic signed [DATA_W-1:0] out_q;
  logic                     sat_q;
  logic                     out_valid_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    scaled;
  logic signed [DATA_W-1:0]   sat_val;
  logic signed [DATA_W-1:0]   final_val;
  logic                       sat_flag;
  logic                       last_pair;

  assign prod      = bus.value * bus.weight;
  assign last_pair = (count == LAST);

  // Bias is aligned to the product's 2*FRAC_W fraction before the add;
  // the arithmetic right shift then truncates toward minus infinity.
  assign sum    = SUM_W'(acc) + (SUM_W'(bus.bias) <<< FRAC_W);
  assign scaled = sum >>> FRAC_W;

  fx_saturate #(
    .IN_W  (SUM_W),
    .OUT_W (DATA_W)
  ) u_sat (
    .in  (scaled),
    .out (sat_val),
    .sat (sat_flag)
  );

  // ReLU leaves the saturation flag alone: a clamped-low result reads 0, sat=1.
  assign final_val = (RELU_EN && sat_val[DATA_W-1]) ? '0 : sat_val;

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && last_pair) state_nxt = FINAL;
      end
      FINAL:   state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      count       <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc   <= acc + ACC_W'(prod);
            count <= last_pair ? '0 : count + 1'b1;
          end
        end
        FINAL: begin
          out_q       <= final_val;
          sat_q       <= sat_flag;
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac.
//   u0 : default parameters (N_INPUTS=10, RELU_EN=1)
//   u1 : N_INPUTS=10, RELU_EN=0
//   u2 : N_INPUTS=1,  RELU_EN=0
// Stimulus pushes hand-computed results into sbq; per-instance monitors pop
// and compare when out_valid rises, and watch HOLD behaviour.
module tb_neuron_mac;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] vv   [3];
  logic [15:0] ww   [3];
  logic [15:0] bb   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ss   [3];
  logic [15:0] oo   [3];

  neuron_mac_if #(.DATA_W(16)) if0 ();
  neuron_mac_if #(.DATA_W(16)) if1 ();
  neuron_mac_if #(.DATA_W(16)) if2 ();

  assign if0.in_valid = iv[0];  assign if0.value = vv[0];  assign if0.weight = ww[0];
  assign if0.bias = bb[0];      assign if0.out_ready = ordy[0];
  assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;
  assign oo[0] = if0.out;       assign ss[0] = if0.sat;

  assign if1.in_valid = iv[1];  assign if1.value = vv[1];  assign if1.weight = ww[1];
  assign if1.bias = bb[1];      assign if1.out_ready = ordy[1];
  assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;
  assign oo[1] = if1.out;       assign ss[1] = if1.sat;

  assign if2.in_valid = iv[2];  assign if2.value = vv[2];  assign if2.weight = ww[2];
  assign if2.bias = bb[2];      assign if2.out_ready = ordy[2];
  assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;
  assign oo[2] = if2.out;       assign ss[2] = if2.sat;

  neuron_mac #(.N_INPUTS(10), .RELU_EN(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  neuron_mac #(.N_INPUTS(10), .RELU_EN(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  neuron_mac #(.N_INPUTS(1),  .RELU_EN(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  typedef struct {
    int          tag;
    logic [15:0] out;
    logic        sat;
    int          period;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input bit ok, input string name, input int k,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d: got %0h need %0h", name, k, act, req);
  endtask

  function automatic logic [31:0] pair(input int set, input int i);
    case (set)
      0: case (i)
           0: return {16'h0014, 16'h0018};
           1: return {16'h0028, 16'h0018};
           2: return {16'h0028, 16'h0050};
           3: return {16'h0020, 16'h0020};
           4: return {16'h0030, 16'h0050};
           5: return {16'h0020, 16'h0030};
           6: return {16'h0014, 16'h0038};
           7: return {16'h0038, 16'h0050};
           8: return {16'h0048, 16'h0040};
           default: return {16'h0020, 16'h0030};
         endcase
      1: return {16'h7FF0, 16'h7FF0};
      2: return {16'h7FF0, 16'h8010};
      3: return {16'hFFF8, 16'h0010};
      default: return {16'hFFFF, 16'h0001};
    endcase
  endfunction

  // Per-instance monitor: compare at the out_valid rise, then police HOLD.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic        prev_ov  = 1'b0;
    logic        acc_pend = 1'b0;
    int          last_hs  = 0;
    int          prev_rise = 0;
    logic [15:0] held_out = '0;
    logic        held_sat = 1'b0;

    always @(negedge clk) begin
      exp_t e;
      if (reset) begin
        prev_ov   = 1'b0;
        acc_pend  = 1'b0;
        prev_rise = 0;
      end else begin
        if (iv[g] && ir[g]) last_hs = cyc + 1;
        if (acc_pend) begin
          check(!ov[g], "ov_drop", g, 32'(ov[g]), 0);
          check(ir[g], "ready_after_accept", g, 32'(ir[g]), 1);
          acc_pend = 1'b0;
        end else if (ov[g]) begin
          check(!ir[g], "hold_in_ready", g, 32'(ir[g]), 0);
          if (!prev_ov) begin
            check(sbq.size() != 0, "unexpected_out_valid", g, 32'(oo[g]), 0);
            if (sbq.size() != 0) begin
              e = sbq.pop_front();
              check(e.tag == g, "tag", g, g, e.tag);
              check(oo[g] == e.out, "out", g, 32'(oo[g]), 32'(e.out));
              check(ss[g] == e.sat, "sat", g, 32'(ss[g]), 32'(e.sat));
              check(cyc - last_hs == 1, "latency", g, cyc - last_hs, 1);
              if (e.period != 0)
                check(cyc - prev_rise == e.period, "period", g, cyc - prev_rise, e.period);
            end
            prev_rise = cyc;
            held_out  = oo[g];
            held_sat  = ss[g];
          end else begin
            check(oo[g] == held_out && ss[g] == held_sat, "hold_stable", g,
                  {15'd0, ss[g], oo[g]}, {15'd0, held_sat, held_out});
          end
          if (ordy[g]) acc_pend = 1'b1;
        end
        prev_ov = ov[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [15:0] o, input logic s, input int per);
    exp_t e;
    e.tag = k; e.out = o; e.sat = s; e.period = per;
    sbq.push_back(e);
  endtask

  // Drives n pairs of a set; a pair advances only when in_ready was high.
  task automatic send(input int k, input int set, input int n, input bit gap);
    int          idx   = 0;
    int          t     = 0;
    bit          phase = 1'b0;
    logic [31:0] p;
    while (idx < n && t < 200) begin
      tick();
      t++;
      p     = pair(set, idx);
      vv[k] = p[31:16];
      ww[k] = p[15:0];
      iv[k] = gap ? phase : 1'b1;
      phase = ~phase;
      if (iv[k] && ir[k]) idx++;
    end
    check(idx == n, "send_timeout", k, idx, n);
  endtask

  task automatic idle(input int k);
    tick();
    iv[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int t = 0;
    while ((sbq.size() != 0 || ov[k]) && t < 100) begin
      tick();
      t++;
    end
    check(t < 100, "drain_timeout", k, t, 100);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; vv[k] = '0; ww[k] = '0; bb[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check(oo[k] == 16'h0000, "reset_out", k, 32'(oo[k]), 0);
      check(ss[k] == 1'b0, "reset_sat", k, 32'(ss[k]), 0);
      check(ov[k] == 1'b0, "reset_out_valid", k, 32'(ov[k]), 0);
      check(ir[k] == 1'b1, "reset_in_ready", k, 32'(ir[k]), 1);
    end
    reset = 1'b0;
    tick();

    // Back-to-back pairs, bias 0: 22784 >>> 4 = 1424.
    push(0, 16'h0590, 1'b0, 0);
    send(0, 0, 10, 1'b0);
    idle(0);
    wait_drain(0);

    // Bias -1.0, gapped input, result held 5 cycles: (22784-256) >>> 4 = 1408.
    bb[0]   = 16'hFFF0;
    ordy[0] = 1'b0;
    push(0, 16'h0580, 1'b0, 0);
    send(0, 0, 10, 1'b1);
    idle(0);
    t = 0;
    while (!ov[0] && t < 50) begin
      tick();
      t++;
    end
    check(t < 50, "hold_wait_timeout", 0, t, 50);
    repeat (5) tick();
    ordy[0] = 1'b1;
    wait_drain(0);
    bb[0] = '0;

    // Saturation high, saturation low under ReLU, saturation low without.
    push(0, 16'h7FFF, 1'b1, 0);
    send(0, 1, 10, 1'b0);
    idle(0);
    wait_drain(0);
    push(0, 16'h0000, 1'b1, 0);
    send(0, 2, 10, 1'b0);
    idle(0);
    wait_drain(0);
    push(1, 16'h8000, 1'b1, 0);
    send(1, 2, 10, 1'b0);
    idle(1);
    wait_drain(1);

    // Negative results: -0.5*1.0 x10 = -5.0; single -1 LSB product floors to -1.
    push(1, 16'hFFB0, 1'b0, 0);
    send(1, 3, 10, 1'b0);
    idle(1);
    wait_drain(1);
    push(2, 16'hFFFF, 1'b0, 0);
    send(2, 4, 1, 1'b0);
    idle(2);
    wait_drain(2);

    // Reset mid-accumulation discards the partial sum.
    send(0, 0, 6, 1'b0);
    tick();
    iv[0] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(0, 16'h0590, 1'b0, 0);
    send(0, 0, 10, 1'b0);
    idle(0);
    wait_drain(0);

    // in_valid held high across three neurons: 12-cycle period.
    push(1, 16'h0590, 1'b0, 0);
    send(1, 0, 10, 1'b0);
    push(1, 16'hFFB0, 1'b0, 12);
    send(1, 3, 10, 1'b0);
    push(1, 16'h0590, 1'b0, 12);
    send(1, 0, 10, 1'b0);
    idle(1);
    wait_drain(1);

    check(sbq.size() == 0, "queue_empty", 0, sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
